// File: rtl/mask_rx.sv
// M-level ASK receiver: rectify, integrate-and-dump per symbol, slice against uniform thresholds,
// track carrier hunt/lock/loss and buffer symbols in a show-ahead FIFO. Define MASK_RX_GRAY_EN for Gray decode.
module mask_rx #(
  parameter int DATA_W        = 16,
  parameter int SYMBOL_PERIOD = 50,
  parameter int BITS_PER_SYM  = 2,
  parameter int FIFO_DEPTH    = 4,
  parameter int IDLE_SYMBOLS  = 8
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     rx_en,
  input  logic signed [DATA_W-1:0] rx_signal,
  input  logic [DATA_W-1:0]        thr_step,
  output logic [BITS_PER_SYM-1:0]  sym_data,
  output logic                     sym_valid,
  input  logic                     sym_ready,
  output logic                     locked,
  output logic                     eof,
  output logic                     overflow
);

  localparam int L     = 1 << BITS_PER_SYM;
  localparam int CNT_W = $clog2(SYMBOL_PERIOD);
  localparam int ACC_W = DATA_W + CNT_W;
  localparam int THR_W = ACC_W + BITS_PER_SYM + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ZR_W  = $clog2(IDLE_SYMBOLS + 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HUNT = 2'd1, ST_LOCK = 2'd2} state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [ACC_W-1:0]        acc_q;
  logic [ZR_W-1:0]         zrun_q;
  logic [PTR_W-1:0]        wr_q;
  logic [PTR_W-1:0]        rd_q;
  logic [PTR_W:0]          count_q;
  logic                    locked_q;
  logic                    eof_q;
  logic                    ovf_q;
  logic [BITS_PER_SYM-1:0] mem_q [FIFO_DEPTH];

  logic [DATA_W-1:0]       rect_s;
  logic [ACC_W-1:0]        sum_d;
  logic [THR_W-1:0]        thr_base_s;
  logic [THR_W-1:0]        thr_k_s;
  logic [BITS_PER_SYM-1:0] idx_s;
  logic [BITS_PER_SYM-1:0] sym_push_s;
  logic                    last_s;
  logic                    pop_s;
  logic                    full_s;
  logic                    push_s;
  logic                    write_s;

  // Full-wave rectifier; the most negative code saturates instead of wrapping.
  always_comb begin
    if (!rx_signal[DATA_W-1]) begin
      rect_s = $unsigned(rx_signal);
    end else if (rx_signal == {1'b1, {(DATA_W-1){1'b0}}}) begin
      rect_s = {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      rect_s = $unsigned(-rx_signal);
    end
  end

  assign sum_d = acc_q + ACC_W'(rect_s);

  // Saturating slicer: count thresholds k*thr_step*SYMBOL_PERIOD that the integral reaches.
  always_comb begin
    thr_base_s = THR_W'(thr_step) * THR_W'(SYMBOL_PERIOD);
    thr_k_s    = '0;
    idx_s      = '0;
    for (int k = 1; k < L; k++) begin
      thr_k_s = thr_k_s + thr_base_s;
      if (THR_W'(sum_d) >= thr_k_s) begin
        idx_s = idx_s + BITS_PER_SYM'(1);
      end else begin
        idx_s = idx_s;
      end
    end
  end

`ifdef MASK_RX_GRAY_EN
  assign sym_push_s = idx_s ^ (idx_s >> 1);
`else
  assign sym_push_s = idx_s;
`endif

  assign last_s  = (cnt_q == CNT_W'(SYMBOL_PERIOD - 1));
  assign pop_s   = (count_q != '0) && sym_ready;
  assign full_s  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign push_s  = sys_rst_n && rx_en && last_s &&
                   ((state_q == ST_LOCK) || ((state_q == ST_HUNT) && (idx_s != '0)));
  assign write_s = push_s && (!full_s || pop_s);

  // Receiver state, integrator, lock tracking and FIFO pointers.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      zrun_q   <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      count_q  <= '0;
      locked_q <= 1'b0;
      eof_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (!rx_en || (state_q == ST_IDLE)) begin
      state_q  <= rx_en ? ST_HUNT : ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      zrun_q   <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      count_q  <= '0;
      locked_q <= 1'b0;
      eof_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      eof_q <= 1'b0;
      if (last_s) begin
        cnt_q <= '0;
        acc_q <= '0;
        case (state_q)
          ST_HUNT: begin
            if (idx_s != '0) begin
              state_q  <= ST_LOCK;
              locked_q <= 1'b1;
              zrun_q   <= '0;
            end
          end
          ST_LOCK: begin
            if (idx_s != '0) begin
              zrun_q <= '0;
            end else if (zrun_q == ZR_W'(IDLE_SYMBOLS - 1)) begin
              state_q  <= ST_HUNT;
              locked_q <= 1'b0;
              eof_q    <= 1'b1;
              zrun_q   <= '0;
            end else begin
              zrun_q <= zrun_q + ZR_W'(1);
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
        acc_q <= sum_d;
      end

      if (write_s) wr_q <= wr_q + PTR_W'(1);
      if (pop_s)   rd_q <= rd_q + PTR_W'(1);
      if (write_s && !pop_s) begin
        count_q <= count_q + (PTR_W+1)'(1);
      end else if (!write_s && pop_s) begin
        count_q <= count_q - (PTR_W+1)'(1);
      end
      // A full FIFO only drops when the consumer is not freeing a slot on the same edge.
      if (push_s && full_s && !pop_s) ovf_q <= 1'b1;
    end
  end

  // FIFO storage; contents need no reset because the occupancy count gates visibility.
  always_ff @(posedge sys_clk) begin
    if (write_s) mem_q[wr_q] <= sym_push_s;
  end

  assign sym_valid = (count_q != '0);
  assign sym_data  = sym_valid ? mem_q[rd_q] : '0;
  assign locked    = locked_q;
  assign eof       = eof_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_mask_rx.sv
// Randomized scoreboard bench for mask_rx: a symbol-level reference model predicts pushed symbols,
// lock/eof/overflow, and a negedge monitor compares everything the DUT presents.
module tb_mask_rx;

  localparam int DATA_W = 16;
  localparam int SP     = 50;
  localparam int BPS    = 2;
  localparam int DEPTH  = 4;
  localparam int IDLE_N = 8;
  localparam int L      = 1 << BPS;
  localparam int AMAX   = (1 << (DATA_W - 1)) - 1;

  logic                     sys_clk;
  logic                     sys_rst_n;
  logic                     rx_en;
  logic signed [DATA_W-1:0] rx_signal;
  logic [DATA_W-1:0]        thr_step;
  logic [BPS-1:0]           sym_data;
  logic                     sym_valid;
  logic                     sym_ready;
  logic                     locked;
  logic                     eof;
  logic                     overflow;

  mask_rx #(
    .DATA_W(DATA_W), .SYMBOL_PERIOD(SP), .BITS_PER_SYM(BPS),
    .FIFO_DEPTH(DEPTH), .IDLE_SYMBOLS(IDLE_N)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx_en(rx_en), .rx_signal(rx_signal),
    .thr_step(thr_step), .sym_data(sym_data), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .locked(locked), .eof(eof), .overflow(overflow)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks   = 0;
  int failures = 0;
  int rdy_mode = 1;
  bit mon_on   = 1'b0;

  // reference model state
  int win_q[$];
  int exp_q[$];
  bit m_active = 1'b0;
  bit m_locked = 1'b0;
  bit m_eof    = 1'b0;
  bit m_ovf    = 1'b0;
  int m_zrun   = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_push(input int sym);
    if (exp_q.size() < DEPTH) exp_q.push_back(sym);
    else m_ovf = 1'b1;
  endtask

  task automatic m_decide(input int s);
    int idx;
    int sym;
    if (thr_step == '0) idx = L - 1;
    else begin
      idx = s / (int'(thr_step) * SP);
      if (idx > L - 1) idx = L - 1;
    end
`ifdef MASK_RX_GRAY_EN
    sym = idx ^ (idx >> 1);
`else
    sym = idx;
`endif
    if (!m_locked) begin
      if (idx != 0) begin
        m_push(sym);
        m_locked = 1'b1;
        m_zrun   = 0;
      end
    end else begin
      m_push(sym);
      if (idx == 0) begin
        m_zrun++;
        if (m_zrun == IDLE_N) begin
          m_eof    = 1'b1;
          m_locked = 1'b0;
          m_zrun   = 0;
        end
      end else begin
        m_zrun = 0;
      end
    end
  endtask

  task automatic model_edge(input int x);
    int a;
    m_eof = 1'b0;
    if (!sys_rst_n || !rx_en) begin
      m_active = 1'b0;
      m_locked = 1'b0;
      m_ovf    = 1'b0;
      m_zrun   = 0;
      win_q.delete();
      exp_q.delete();
    end else if (!m_active) begin
      m_active = 1'b1;
      win_q.delete();
    end else begin
      a = (x < 0) ? -x : x;
      if (a > AMAX) a = AMAX;
      win_q.push_back(a);
      if (win_q.size() == SP) begin
        m_decide(win_q.sum());
        win_q.delete();
      end
    end
  endtask

  // one clock: drive sample and ready, then update the model at the sampling edge
  task automatic cycle(input int x, input bit last);
    rx_signal = x[DATA_W-1:0];
    case (rdy_mode)
      0:       sym_ready = 1'b0;
      1:       sym_ready = 1'b1;
      2:       sym_ready = 1'($urandom_range(0, 1));
      default: sym_ready = last;
    endcase
    @(posedge sys_clk);
    model_edge(x);
    #1;
  endtask

  // smode: 0 random sign of amp, 1 always -amp, 2 uniform noise in [-amp, amp]
  task automatic send_part(input int amp, input int n, input int smode);
    int x;
    for (int i = 0; i < n; i++) begin
      if (smode == 1) x = -amp;
      else if (smode == 2) x = int'($urandom_range(0, 2 * amp)) - amp;
      else x = ($urandom_range(0, 1) != 0) ? amp : -amp;
      cycle(x, i == n - 1);
    end
  endtask

  task automatic send_sym(input int amp);
    send_part(amp, SP, 0);
  endtask

  // Scoreboard monitor: compares at the falling edge, pops when the handshake will complete.
  always @(negedge sys_clk) begin
    if (mon_on) begin
      chk("sym_valid", int'(sym_valid), int'(exp_q.size() != 0));
      if (sym_valid && (exp_q.size() != 0)) begin
        chk("sym_data", int'(sym_data), exp_q[0]);
        if (sym_ready) void'(exp_q.pop_front());
      end
      chk("locked", int'(locked), int'(m_locked));
      chk("eof", int'(eof), int'(m_eof));
      chk("overflow", int'(overflow), int'(m_ovf));
    end
  end

  initial begin
    int amp;
    int k;
    int exp_first;
    sys_rst_n = 1'b0;
    rx_en     = 1'b0;
    rx_signal = '0;
    thr_step  = 16'd1000;
    sym_ready = 1'b1;
    cycle(0, 1'b0);
    mon_on = 1'b1;
    cycle(0, 1'b0);
    cycle(0, 1'b0);
    @(negedge sys_clk);
    chk("rst_sym_data", int'(sym_data), 0);
    chk("rst_valid", int'(sym_valid), 0);
    chk("rst_locked", int'(locked), 0);

    // noise then carrier
    sys_rst_n = 1'b1;
    rx_en     = 1'b1;
    cycle(0, 1'b0);
    repeat (3) send_sym(200);
    send_sym(2500);
`ifdef MASK_RX_GRAY_EN
    exp_first = 3;
`else
    exp_first = 2;
`endif
    @(negedge sys_clk);
    chk("first_sym", int'(sym_data), exp_first);
    chk("first_locked", int'(locked), 1);

    // level sweep including the saturating negative code
    send_sym(999);
    send_sym(1000);
    send_sym(2000);
    send_sym(3000);
    send_sym(32767);
    send_part(32768, SP, 1);

    // carrier loss then relock
    repeat (IDLE_N) send_sym(0);
    @(negedge sys_clk);
    chk("loss_eof", int'(eof), 1);
    chk("loss_locked", int'(locked), 0);
    send_sym(2000);

    // backpressure overflow
    rdy_mode = 0;
    repeat (6) send_sym(3000);
    @(negedge sys_clk);
    chk("bp_overflow", int'(overflow), 1);
    chk("bp_valid", int'(sym_valid), 1);

    // rx_en drop mid-LOCK flushes and clears overflow
    send_part(3000, 25, 0);
    rx_en = 1'b0;
    cycle(0, 1'b0);
    rx_en = 1'b1;
    @(negedge sys_clk);
    chk("rxen_overflow", int'(overflow), 0);
    chk("rxen_valid", int'(sym_valid), 0);
    cycle(0, 1'b0);

    // full FIFO with simultaneous pop on the decision edge
    repeat (4) send_sym(2000);
    rdy_mode = 3;
    send_sym(1000);
    @(negedge sys_clk);
    chk("fullpop_overflow", int'(overflow), 0);

    // reset mid-symbol with entries held
    rdy_mode = 1;
    send_sym(1000);
    rdy_mode = 0;
    send_sym(2000);
    send_sym(3000);
    send_part(3000, 25, 0);
    sys_rst_n = 1'b0;
    cycle(0, 1'b0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    chk("mrst_sym_data", int'(sym_data), 0);
    chk("mrst_valid", int'(sym_valid), 0);
    chk("mrst_locked", int'(locked), 0);
    rdy_mode = 1;
    cycle(0, 1'b0);
    send_sym(1500);

    // randomized symbols, thresholds and consumer stalls
    rdy_mode = 2;
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 5))
        0:       amp = 0;
        1:       amp = 32767;
        default: amp = int'($urandom_range(0, 4000));
      endcase
      k = int'($urandom_range(1, SP - 1));
      send_part(amp, k, 2);
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0:       thr_step = 16'd0;
          1:       thr_step = 16'd1000;
          2:       thr_step = 16'd500;
          default: thr_step = 16'($urandom_range(1, 3000));
        endcase
      end
      send_part(amp, SP - k, 2);
    end

    rdy_mode = 1;
    send_part(0, 20, 0);
    mon_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mask_rx.md
# mask_rx

Parametrised M-level ASK receiver: full-wave rectifies a signed baseband/IF sample stream, integrates and dumps over each symbol period, and slices the integral against uniformly spaced thresholds into a `BITS_PER_SYM`-bit symbol. It is the multi-level, handshaked successor of the team's 2ASK receiver. It sits between the ADC/sample path and the bit unpacker/framer, and adds:
- carrier hunt/lock/loss tracking,
- a small output FIFO with valid/ready flow control,
- optional Gray decoding.

## Interface
- `DATA_W`, 16, width of signed input sample
- `SYMBOL_PERIOD`, 50, samples (clocks) per symbol, ≥2
- `BITS_PER_SYM`, 2, bits per symbol; levels L = 2^BITS_PER_SYM, 1..4
- `FIFO_DEPTH`, 4, output FIFO entries, power of two ≥2
- `IDLE_SYMBOLS`, 8, consecutive zero symbols that declare carrier loss, ≥1

Ports:
- `sys_clk` in 1: system clock, all logic on rising edge
- `sys_rst_n` in 1: reset, synchronous, active-low
- `rx_en` in 1: receiver enable; low forces IDLE
- `rx_signal` in DATA_W: signed two's-complement sample, one per clock
- `thr_step` in DATA_W: unsigned per-sample amplitude step between levels
- `sym_data` out BITS_PER_SYM: FIFO head symbol
- `sym_valid` out 1: FIFO non-empty
- `sym_ready` in 1: consumer accepts head when `sym_valid` & `sym_ready`
- `locked` out 1: high in LOCK state
- `eof` out 1: one-cycle pulse on carrier loss
- `overflow` out 1: sticky, a decided symbol was dropped because the FIFO was full

## Operation
- **Rectifier:** `|rx_signal|`. The most negative input saturates to 2^(DATA_W-1)-1.
- **Accumulator:** ACC_W = DATA_W + clog2(SYMBOL_PERIOD) bits. It never overflows.
- **Sample counter:** counts 0..SYMBOL_PERIOD-1.
- **Decision:** made on the cycle the counter equals SYMBOL_PERIOD-1.
  - S = acc + current rectified sample, so all SYMBOL_PERIOD samples are included.
  - index = count of k in 1..L-1 with S ≥ k·thr_step·SYMBOL_PERIOD. This is a saturating floor; no divider.
  - On that cycle the accumulator reloads to 0 and the counter wraps to 0.
- **States:**
  - IDLE: counter and accumulator held at 0, FIFO flushed, `overflow` cleared. Enter on `rx_en`=0 from any state. Leave to HUNT when `rx_en`=1.
  - HUNT: decisions made but discarded. The first decision with index≠0 is pushed and moves to LOCK.
  - LOCK: every decision is pushed, including zeros. A zero-run counter increments on index=0 and clears on index≠0. When it reaches IDLE_SYMBOLS: pulse `eof` on the next cycle, go to HUNT, clear the run counter. The zero symbol that completed the run is still pushed.
- **FIFO:**
  - Show-ahead; `sym_data` is valid whenever `sym_valid`=1.
  - A push when full with no simultaneous pop drops the new symbol and sets `overflow`.
  - Push and pop in the same cycle when full is legal and does not overflow.
  - Push and pop in the same cycle when empty: the pushed symbol is stored, nothing pops.
- **`thr_step`:** sampled only on the decision cycle. Changes mid-symbol take effect at the next decision. `thr_step`=0 yields index L-1 for every symbol.

## Timing
- Reset values (`sys_rst_n` low at a rising edge): `sym_valid`=0, `sym_data`=0, `locked`=0, `eof`=0, `overflow`=0. State IDLE, counters and FIFO pointers 0. Reset mid-symbol discards the partial integral and all FIFO contents.
- The first symbol window starts at the first rising edge with state HUNT: the cycle after `rx_en` is seen high in IDLE.
- Latency: the symbol is written at the edge that samples its last input. `sym_valid` is high in the following cycle.
- `locked`: rises in the same cycle `sym_valid` first shows the frame's first symbol. It falls in the same cycle `eof` pulses.
- Throughput: one symbol per SYMBOL_PERIOD clocks, so the consumer may stall up to FIFO_DEPTH·SYMBOL_PERIOD−1 cycles without loss.
- `rx_en` deassertion takes effect at the next edge. Any in-flight decision on that edge is discarded.

## Configuration
- `MASK_RX_GRAY_EN` defined: the pushed symbol is `index ^ (index >> 1)` (Gray decode, matching Gray-mapped TX levels). HUNT/LOCK and zero-run logic use the raw index; index 0 maps to 0 either way.
- Undefined: the pushed symbol is the raw binary index.

## Test plan
Default parameters, `thr_step`=1000 unless stated, so the integral thresholds are 50000, 100000 and 150000.
1. Noise then carrier: 3 symbols of ±200, then one symbol of ±2500 (S=125000) → nothing pushed in HUNT; `sym_data`=2 (3 with GRAY_EN) and `locked`=1 one cycle after the 200th sample.
2. Level sweep in LOCK: per-symbol amplitudes 999, 1000, 2000, 3000, 32767 and input −32768 → indices 0, 1, 2, 3, 3, 3. The saturating rectifier must not wrap.
3. Carrier loss: lock, then 8 zero-amplitude symbols → 8 zeros pushed; `eof` pulses once, one cycle after the 8th decision; `locked` drops; the next nonzero symbol relocks.
4. Backpressure: `sym_ready`=0 for 6 symbols in LOCK → 4 stored, `overflow`=1, `sym_data` order preserved. With `sym_ready`=1 held on a full FIFO at a decision edge → no overflow.
5. Synchronous reset with `sys_rst_n` low for 1 cycle at sample 25 of a symbol, FIFO holding 2 entries → all outputs 0 the next cycle. Integration restarts cleanly and the first post-reset decision equals a fresh 50-sample sum.
6. `rx_en` dropped for 1 cycle mid-LOCK → FIFO flushed, `overflow` cleared, `locked`=0, HUNT restarts with a full-length window.
